// File: rtl/x_pulse_conditioner.sv
// Conditions a raw asynchronous line into one single-cycle x_pulse per debounced rising edge.
// Also reports the debounced level, a qualification-busy flag and a wrapping pulse count.
module x_pulse_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             en,
  output logic             x_pulse,
  output logic             level,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_count
);

  localparam logic [1:0] LOW      = 2'd0;
  localparam logic [1:0] RISE_CHK = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] FALL_CHK = 2'd3;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] cnt_nxt;
  logic            rise_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Any sample disagreeing with the candidate level drops straight back to the stable state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = db_cnt;
    rise_done = 1'b0;
    case (state)
      LOW: begin
        if (sync2) begin
          state_nxt = RISE_CHK;
          cnt_nxt   = DB_W'(1);
        end
      end
      RISE_CHK: begin
        if (!sync2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          rise_done = 1'b1;
        end else begin
          cnt_nxt = db_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!sync2) begin
          state_nxt = FALL_CHK;
          cnt_nxt   = DB_W'(1);
        end
      end
      FALL_CHK: begin
        if (sync2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= LOW;
      db_cnt      <= '0;
      x_pulse     <= 1'b0;
      level       <= 1'b0;
      busy        <= 1'b0;
      pulse_count <= '0;
    end else begin
      state   <= state_nxt;
      db_cnt  <= cnt_nxt;
      level   <= (state_nxt == HIGH) || (state_nxt == FALL_CHK);
      busy    <= (state_nxt == RISE_CHK) || (state_nxt == FALL_CHK);
      x_pulse <= rise_done && en;
      if (rise_done && en) begin
        pulse_count <= pulse_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_x_pulse_conditioner.sv
// Bench for x_pulse_conditioner: reference table, directed corner sequences and random
// stimulus checked against a sliding-window debounce model.
module tb_x_pulse_conditioner;

  localparam int DB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          raw_in;
  logic          en;
  logic          x_pulse;
  logic          level;
  logic          busy;
  logic [CW-1:0] pulse_count;

  int n_checks = 0;
  int n_pass   = 0;
  int dut_pulses = 0;
  int busy_seen  = 0;
  int level_seen = 0;

  always #5 clk = ~clk;

  x_pulse_conditioner #(.DB_CYCLES(DB), .DB_W(3), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .en(en),
    .x_pulse(x_pulse),
    .level(level),
    .busy(busy),
    .pulse_count(pulse_count)
  );

  typedef struct {
    logic          raw;
    logic          en;
    logic          x;
    logic          lvl;
    logic          bsy;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[13];

  // Model: raw is seen by the debouncer two edges late; the level flips once the last DB
  // observed samples all disagree with it.
  logic          raw_q[$];
  logic          s_win[$];
  logic          m_level;
  logic          m_pulse;
  logic          m_busy;
  logic [CW-1:0] m_count;

  function automatic void modelReset();
    raw_q = {1'b0, 1'b0};
    s_win.delete();
    for (int i = 0; i < DB; i++) s_win.push_back(1'b0);
    m_level = 1'b0;
    m_pulse = 1'b0;
    m_busy  = 1'b0;
    m_count = '0;
  endfunction

  function automatic void modelEdge(input logic r, input logic e);
    logic s;
    logic flip;
    raw_q.push_back(r);
    s = raw_q[0];
    void'(raw_q.pop_front());
    s_win.push_back(s);
    void'(s_win.pop_front());
    flip = 1'b1;
    foreach (s_win[i]) if (s_win[i] == m_level) flip = 1'b0;
    m_pulse = 1'b0;
    if (flip) begin
      m_level = !m_level;
      if (m_level && e) begin
        m_pulse = 1'b1;
        m_count = m_count + 1'b1;
      end
    end
    m_busy = !flip && (s != m_level);
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput();
    check("x_pulse", CW'(x_pulse), CW'(m_pulse));
    check("level", CW'(level), CW'(m_level));
    check("busy", CW'(busy), CW'(m_busy));
    check("pulse_count", pulse_count, m_count);
    if (x_pulse === 1'b1) dut_pulses++;
    if (busy === 1'b1) busy_seen = 1;
    if (level === 1'b1) level_seen = 1;
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, samples at the next fall.
  task automatic applyStimulus(input logic r, input logic e);
    raw_in = r;
    en     = e;
    @(posedge clk);
    modelEdge(r, e);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkZero(input string name);
    check({name, "_x"}, CW'(x_pulse), '0);
    check({name, "_lvl"}, CW'(level), '0);
    check({name, "_busy"}, CW'(busy), '0);
    check({name, "_cnt"}, pulse_count, '0);
  endtask

  task automatic doReset();
    #2 reset = 1'b0;
    #1 checkZero("async_rst");
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic press(input int hi, input int lo, input logic e);
    for (int i = 0; i < hi; i++) applyStimulus(1'b1, e);
    for (int i = 0; i < lo; i++) applyStimulus(1'b0, e);
  endtask

  initial begin
    int p0;
    logic [CW-1:0] c0;
    int pulse_idx;
    logic r;

    tbl[0]  = '{1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 1, 0};
    tbl[5]  = '{1, 1, 1, 1, 0, 1};
    tbl[6]  = '{1, 1, 0, 1, 0, 1};
    tbl[7]  = '{0, 1, 0, 1, 0, 1};
    tbl[8]  = '{0, 1, 0, 1, 0, 1};
    tbl[9]  = '{0, 1, 0, 1, 1, 1};
    tbl[10] = '{0, 1, 0, 1, 1, 1};
    tbl[11] = '{0, 1, 0, 1, 1, 1};
    tbl[12] = '{0, 1, 0, 0, 0, 1};

    reset  = 1'b0;
    raw_in = 1'b0;
    en     = 1'b1;
    modelReset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      raw_in = ~raw_in;
      #2 checkZero("rst_hold");
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].raw, tbl[i].en);
      check("tbl_x_pulse", CW'(x_pulse), CW'(tbl[i].x));
      check("tbl_level", CW'(level), CW'(tbl[i].lvl));
      check("tbl_busy", CW'(busy), CW'(tbl[i].bsy));
      check("tbl_count", pulse_count, tbl[i].cnt);
    end

    p0 = dut_pulses;
    c0 = pulse_count;
    busy_seen = 0;
    level_seen = 0;
    press(3, 10, 1'b1);
    check("glitch_pulses", CW'(dut_pulses - p0), '0);
    check("glitch_busy_seen", CW'(busy_seen), 8'd1);
    check("glitch_level_seen", CW'(level_seen), '0);
    check("glitch_count", pulse_count, c0);

    doReset();
    p0 = dut_pulses;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
      check("bounce_level_low", CW'(level), '0);
    end
    check("bounce_pulses", CW'(dut_pulses - p0), 8'd4);
    check("bounce_count", pulse_count, 8'd4);

    p0 = dut_pulses;
    level_seen = 0;
    press(8, 10, 1'b0);
    check("en_off_level_seen", CW'(level_seen), 8'd1);
    check("en_off_pulses", CW'(dut_pulses - p0), '0);
    check("en_off_count", pulse_count, 8'd4);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    check("en_late_level", CW'(level), 8'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
    check("en_late_pulses", CW'(dut_pulses - p0), '0);
    check("en_late_count", pulse_count, 8'd4);

    doReset();
    for (int k = 0; k < 255; k++) press(6, 6, 1'b1);
    check("wrap_255", pulse_count, 8'd255);
    press(6, 6, 1'b1);
    check("wrap_256", pulse_count, 8'd0);

    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    check("midrst_busy", CW'(busy), 8'd1);
    doReset();
    pulse_idx = -1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (x_pulse === 1'b1 && pulse_idx < 0) pulse_idx = i;
    end
    check("midrst_pulse_idx", CW'(pulse_idx), 8'd5);
    check("midrst_count", pulse_count, 8'd1);

    r = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int len;
      len = $urandom_range(1, 8);
      r = ~r;
      for (int i = 0; i < len; i++) applyStimulus(r, $urandom_range(0, 9) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
